// File: rtl/mux41_pkg.sv
// Shared types and helpers for the round-robin select generator of the 4:1 mux.
package mux41_pkg;

    localparam int unsigned NCH = 4;

    typedef enum logic {
        StIdle,
        StHold
    } state_e;

    // Channel index as driven onto {sel1, sel2}: 0->a, 1->b, 2->c, 3->d.
    typedef logic [1:0] ch_idx_t;

    function automatic logic [NCH-1:0] onehot4(ch_idx_t idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating priority encoder: first requester at or after ptr+1 (mod 4), ptr itself last.
module rr_pick4
    import mux41_pkg::*;
(
    input  logic [NCH-1:0] req,
    input  ch_idx_t        ptr,
    output ch_idx_t        idx,
    output logic           any
);

    ch_idx_t cand;

    // Scan from lowest to highest priority so the nearest requester after ptr wins.
    always_comb begin
        idx  = ptr;
        any  = 1'b0;
        cand = ptr;
        for (int i = NCH; i >= 1; i--) begin
            cand = ptr + ch_idx_t'(i);
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux41_rr_sel.sv
// Round-robin select generator for the 4:1 mux: grants one requesting channel for
// DWELL cycles, drives {sel1, sel2}, and flags valid/grant/last. All outputs registered.
module mux41_rr_sel
    import mux41_pkg::*;
#(
    parameter int unsigned DWELL = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [NCH-1:0] req,
    output logic           sel1,
    output logic           sel2,
    output logic           valid,
    output logic [NCH-1:0] grant,
    output logic           last
);

    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ch_idx_t          ptr_q, ptr_d;
    ch_idx_t          sel_q, sel_d;
    logic             valid_q, valid_d;
    logic [NCH-1:0]   grant_q, grant_d;
    logic             last_q, last_d;

    ch_idx_t          pick_idx;
    logic             pick_any;
    logic             load;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Next-state: arbitrate from idle or at dwell expiry; en low always drops to idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        load    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (en && pick_any) begin
                    load = 1'b1;
                end
            end
            StHold: begin
                if (!en) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    if (pick_any) begin
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
        endcase

        if (load) begin
            state_d = StHold;
            sel_d   = pick_idx;
            ptr_d   = pick_idx;
            cnt_d   = CntLoad;
        end

        // sel keeps its last value in idle so the mux select does not glitch.
        valid_d = (state_d == StHold);
        grant_d = valid_d ? onehot4(sel_d) : '0;
        last_d  = valid_d && (cnt_d == '0);
    end

    // State and output registers; pointer resets to 3 so channel 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ptr_q   <= ch_idx_t'(3);
            sel_q   <= '0;
            valid_q <= 1'b0;
            grant_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign sel1  = sel_q[1];
    assign sel2  = sel_q[0];
    assign valid = valid_q;
    assign grant = grant_q;
    assign last  = last_q;

endmodule

// File: tb/tb_mux41_rr_sel.sv
// Bench for mux41_rr_sel: four instances with different dwell lengths share stimulus
// and are compared each cycle against a grant/remaining-cycles reference model.
module tb_mux41_rr_sel;

    localparam int unsigned NDUT = 4;
    localparam int unsigned DWS [NDUT] = '{1, 2, 4, 8};

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] req;

    logic       s1 [NDUT];
    logic       s2 [NDUT];
    logic       vl [NDUT];
    logic       ls [NDUT];
    logic [3:0] gr [NDUT];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: active flag, granted channel, rr pointer, grant cycles left.
    int m_valid [NDUT];
    int m_ch    [NDUT];
    int m_ptr   [NDUT];
    int m_rem   [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mux41_rr_sel #(
            .DWELL (DWS[g]),
            .CNT_W (3)
        ) u_dut (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .req   (req),
            .sel1  (s1[g]),
            .sel2  (s2[g]),
            .valid (vl[g]),
            .grant (gr[g]),
            .last  (ls[g])
        );
    end

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_valid[k] = 0;
            m_ch[k]    = 0;
            m_ptr[k]   = 3;
            m_rem[k]   = 0;
        end
    endtask

    task automatic arbitrate(input int k);
        int c;
        m_valid[k] = 0;
        for (int off = 1; off <= 4; off++) begin
            c = (m_ptr[k] + off) % 4;
            if (req[c] && m_valid[k] == 0) begin
                m_valid[k] = 1;
                m_ch[k]    = c;
                m_ptr[k]   = c;
                m_rem[k]   = int'(DWS[k]);
            end
        end
    endtask

    task automatic model_edge(input int k);
        if (m_valid[k] != 0) begin
            if (!en) begin
                m_valid[k] = 0;
            end else begin
                m_rem[k] = m_rem[k] - 1;
                if (m_rem[k] == 0) begin
                    if (req != 4'b0000) arbitrate(k);
                    else m_valid[k] = 0;
                end
            end
        end else if (en && req != 4'b0000) begin
            arbitrate(k);
        end
    endtask

    task automatic check_all();
        logic [7:0] obs;
        logic [7:0] exp;
        logic [1:0] chv;
        logic [3:0] gexp;
        logic       vexp;
        logic       lexp;
        for (int k = 0; k < NDUT; k++) begin
            chv  = 2'(m_ch[k]);
            vexp = (m_valid[k] != 0);
            gexp = vexp ? (4'b0001 << m_ch[k]) : 4'b0000;
            lexp = vexp && (m_rem[k] == 1);
            exp  = {chv, vexp, gexp, lexp};
            obs  = {s1[k], s2[k], vl[k], gr[k], ls[k]};
            checks++;
            assert (obs === exp) else begin
                errors++;
                $error("FAIL dut%0d(DWELL=%0d) cycle %0d {sel1,sel2,valid,grant,last}: got %b required %b",
                       k, DWS[k], cyc, obs, exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (!rst) begin
            for (int k = 0; k < NDUT; k++) model_edge(k);
        end
        #1;
        check_all();
    endtask

    // Called 1 time unit after an edge: reset pulse sits fully between clock edges.
    task automatic pulse_rst();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        #2;
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        req = 4'b1111;
        model_reset();
        #1;
        check_all();
        run(2);
        #3;
        rst = 1'b0;

        // All requesting right out of reset: channel 0 first, then rotation.
        run(12);

        // Single requester, re-granted back to back.
        req = 4'b0100;
        run(12);

        // Requester drops mid-dwell; grant still runs to completion.
        req = 4'b0010;
        run(2);
        req = 4'b0000;
        run(10);

        // Enable drop in the middle of a rotation, then re-enable.
        req = 4'b1111;
        run(6);
        en = 1'b0;
        run(2);
        en = 1'b1;
        run(8);

        // Asynchronous reset mid-grant, then arbitration restarts at channel 0.
        run(3);
        pulse_rst();
        run(6);

        // Randomised traffic with occasional enable drops and reset pulses.
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 9) != 0);
            req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0) pulse_rst();
            step();
            if ($urandom_range(0, 3) != 0) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
